// File: rtl/ysyx_040750_resp_demux_nbit_mport.sv
// Response demultiplexer: steers responses from one shared downstream channel
// back to the requester that issued the matching request. One-hot requester
// tags are queued in order at request accept and consumed at response accept.
// A single registered output stage gives one cycle of response-to-port latency.
module ysyx_040750_resp_demux_nbit_mport #(
  parameter int N = 64,
  parameter int M = 4,
  parameter int D = 4
) (
  input  logic             I_sys_clk,
  input  logic             I_rst,
  input  logic             I_req_fire,
  input  logic [M-1:0]     I_req_sel,
  output logic             O_tag_full,
  output logic             O_tag_empty,
  input  logic             I_resp_valid,
  input  logic [N-1:0]     I_resp_data,
  output logic             O_resp_ready,
  output logic [M-1:0]     O_port_valid,
  output logic [N*M-1:0]   O_port_data,
  input  logic [M-1:0]     I_port_ready,
  output logic             O_err
);

  localparam int AW = $clog2(D);
  localparam logic [AW:0]  PTR_ONE = (AW+1)'(1);
  localparam logic [M-1:0] SEL_ONE = M'(1);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [M-1:0] tag_mem_q [D];
  logic [M-1:0] tag_mem_d [D];
  logic         out_valid_q, out_valid_d;
  logic [M-1:0] out_tag_q, out_tag_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic         err_q, err_d;

  logic         tag_full;
  logic         tag_empty;
  logic         sel_onehot;
  logic         push;
  logic         push_reject;
  logic         out_fire;
  logic         resp_ready;
  logic         resp_acc;
  logic [M-1:0] head_tag;

  // Occupancy flags from the wrap-bit pointer pair; full is judged before any pop this cycle
  always_comb begin
    tag_empty = (wr_ptr_q == rd_ptr_q);
    tag_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head_tag  = tag_mem_q[rd_ptr_q[AW-1:0]];
  end

  // Handshake decode: legal pushes, rejected pushes, output drain and response accept
  always_comb begin
    sel_onehot  = (I_req_sel != '0) && ((I_req_sel & (I_req_sel - SEL_ONE)) == '0);
    push        = I_req_fire && !tag_full && sel_onehot;
    push_reject = I_req_fire && (tag_full || !sel_onehot);
    out_fire    = out_valid_q && (|(out_tag_q & I_port_ready));
    resp_ready  = !tag_empty && (!out_valid_q || out_fire);
    resp_acc    = I_resp_valid && resp_ready;
  end

  // Next-state for tag storage, pointers, output stage and the sticky error
  always_comb begin
    tag_mem_d   = tag_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    err_d       = err_q | push_reject;

    if (push) begin
      tag_mem_d[wr_ptr_q[AW-1:0]] = I_req_sel;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (resp_acc) begin
      out_valid_d = 1'b1;
      out_tag_d   = head_tag;
      out_data_d  = I_resp_data;
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops all queued tags and any held response
  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < D; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      tag_mem_q   <= tag_mem_d;
    end
  end

  assign O_tag_full   = tag_full;
  assign O_tag_empty  = tag_empty;
  assign O_resp_ready = resp_ready;
  assign O_port_valid = {M{out_valid_q}} & out_tag_q;
  assign O_err        = err_q;

  // Only the addressed port sees data; every other slice is forced to zero
  for (genvar gi = 0; gi < M; gi++) begin : g_port_data
    assign O_port_data[gi*N +: N] = (out_valid_q && out_tag_q[gi]) ? out_data_q : '0;
  end

endmodule
